// File: rtl/cache_tag_pkg.sv
// Shared types and sizing for the cache tag SRAM controller.
// No logic; purely declarations.
// Word layout: [21] valid, [20] dirty, [19:0] tag.
package cache_tag_pkg;

    localparam int SETS    = 32;
    localparam int INDEX_W = 5;
    localparam int TAG_W   = 20;
    localparam int DATA_W  = TAG_W + 2;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        LOOKUP
    } state_t;

endpackage

// File: rtl/cache_tag_ctrl.sv
// Cache tag SRAM initiator: invalidation sweep after reset, then tag lookups and fills.
// Latency: fill is one cycle; a lookup result is visible two cycles after the request cycle.
// Backpressure: req_ready drops while a result is held unconsumed; at most one result is buffered.
module cache_tag_ctrl
    import cache_tag_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [INDEX_W-1:0] req_set,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               req_dirty,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic               rsp_dirty,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               init_done,
    output logic               sram_csb,
    output logic               sram_web,
    output logic [INDEX_W-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_din,
    input  logic [DATA_W-1:0]  sram_dout
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_cnt;
    logic [TAG_W-1:0]   r_cmp_tag;
    logic               r_rsp_valid;
    logic               r_rsp_hit;
    logic               r_rsp_dirty;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_init_done;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_sweep_last;
    tag_entry_t         w_rd_entry;
    tag_entry_t         w_wr_entry;

    assign w_sweep_last = (r_cnt == INDEX_W'(SETS - 1));
    assign w_accept     = req_valid && w_req_ready;
    // The macro presents the word addressed on the previous edge.
    assign w_rd_entry   = sram_dout;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: sweep all sets, then idle; a lookup spends one cycle waiting on the macro.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (w_sweep_last) w_state_nxt = IDLE;
            IDLE:    if (w_accept && !req_we) w_state_nxt = LOOKUP;
            LOOKUP:  w_state_nxt = IDLE;
            default: w_state_nxt = INIT;
        endcase
    end

    // Outputs: request ready and combinational SRAM drive; macro deselected unless accessing.
    always_comb begin
        w_req_ready = 1'b0;
        sram_csb    = 1'b1;
        sram_web    = 1'b1;
        sram_addr   = '0;
        w_wr_entry  = '0;
        case (r_state)
            INIT: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = r_cnt;
            end
            IDLE: begin
                // A lookup may only start when the single result slot is (or is becoming) free.
                w_req_ready = !r_rsp_valid || rsp_ready;
                if (req_valid && w_req_ready) begin
                    sram_csb  = 1'b0;
                    sram_web  = !req_we;
                    sram_addr = req_set;
                    if (req_we) begin
                        w_wr_entry.valid = 1'b1;
                        w_wr_entry.dirty = req_dirty;
                        w_wr_entry.tag   = req_tag;
                    end
                end
            end
            default: ;
        endcase
        // Keep the macro quiet while reset is held, whatever the state register says.
        if (!rst_n) begin
            sram_csb = 1'b1;
            sram_web = 1'b1;
        end
    end

    assign sram_din = w_wr_entry;

    // Datapath: sweep counter, compare tag capture, response slot and init flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_cmp_tag   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_dirty <= 1'b0;
            r_rsp_tag   <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == INIT) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_sweep_last) r_init_done <= 1'b1;
            end
            if (r_state == IDLE && w_accept && !req_we) begin
                r_cmp_tag <= req_tag;
            end
            if (r_state == LOOKUP) begin
                r_rsp_valid <= 1'b1;
                r_rsp_hit   <= w_rd_entry.valid && (w_rd_entry.tag == r_cmp_tag);
                r_rsp_dirty <= w_rd_entry.dirty;
                r_rsp_tag   <= w_rd_entry.tag;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_dirty = r_rsp_dirty;
    assign rsp_tag   = r_rsp_tag;
    assign init_done = r_init_done;

endmodule
